// File: rtl/k_means_sequencer.sv
// Frame-level controller for the k-means centroid engine: seeds and resets the engine
// each frame, gates the mask stream into it, and publishes tracked results under a watchdog.
module k_means_sequencer #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int WIDTH          = 320,
    parameter int HEIGHT         = 180
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            frame_start_in,
    input  logic            frame_end_in,
    input  logic            pixel_valid_in,
    input  logic [2:0]      num_balls_in,
    input  logic            reseed_in,
    output logic            km_rst_out,
    output logic [6:0][8:0] km_centroids_x_out,
    output logic [6:0][7:0] km_centroids_y_out,
    output logic [2:0]      km_num_balls_out,
    output logic            km_pixel_valid_out,
    output logic            km_new_frame_out,
    input  logic            km_valid_in,
    input  logic [6:0][8:0] km_centroids_x_in,
    input  logic [6:0][7:0] km_centroids_y_in,
    output logic [6:0][8:0] centroids_x_out,
    output logic [6:0][7:0] centroids_y_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            timeout_out,
    output logic [7:0]      drop_count_out
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // Seed i defaults to x = 48*i + 24 (evenly spread across the frame), y = 90 (mid-height).
    localparam logic [6:0][8:0] DEFAULT_X = {9'd312, 9'd264, 9'd216, 9'd168, 9'd120, 9'd72, 9'd24};
    localparam logic [6:0][7:0] DEFAULT_Y = {7{8'd90}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_SOLVE,
        S_ABORT
    } state_e;

    state_e          state_q,     state_d;
    logic [6:0][8:0] seed_x_q,    seed_x_d;
    logic [6:0][7:0] seed_y_q,    seed_y_d;
    logic [6:0][8:0] pub_x_q,     pub_x_d;
    logic [6:0][7:0] pub_y_q,     pub_y_d;
    logic [2:0]      num_balls_q, num_balls_d;
    logic            valid_q,     valid_d;
    logic            timeout_q,   timeout_d;
    logic            new_frame_q, new_frame_d;
    logic            pending_q,   pending_d;
    logic [7:0]      drop_q,      drop_d;
    logic [WD_W-1:0] wd_q,        wd_d;

    logic [2:0] nb_clamped;
    logic       reseed_req;
    logic       drop_event;

    assign nb_clamped = (num_balls_in == 3'd0) ? 3'd1 : num_balls_in;
    assign reseed_req = pending_q | reseed_in;
    assign drop_event = frame_start_in &&
                        (state_q == S_CAPTURE || state_q == S_SOLVE || state_q == S_ABORT);

    // NOTE: every variable gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        seed_x_d    = seed_x_q;
        seed_y_d    = seed_y_q;
        pub_x_d     = pub_x_q;
        pub_y_d     = pub_y_q;
        num_balls_d = num_balls_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        new_frame_d = 1'b0;
        pending_d   = reseed_req;
        drop_d      = drop_q;
        wd_d        = wd_q;

        if (drop_event && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    num_balls_d = nb_clamped;
                    if (nb_clamped != num_balls_q || reseed_req) begin
                        seed_x_d  = DEFAULT_X;
                        seed_y_d  = DEFAULT_Y;
                        pending_d = 1'b0;
                    end
                    state_d = S_ARM;
                end
            end
            S_ARM: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (frame_end_in) begin
                    new_frame_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_SOLVE;
                end
            end
            S_SOLVE: begin
                // A result arriving on the expiry cycle still wins over the abort.
                if (km_valid_in) begin
                    pub_x_d = km_centroids_x_in;
                    pub_y_d = km_centroids_y_in;
                    valid_d = 1'b1;
                    for (int i = 0; i < 7; i++) begin
                        if (32'(km_centroids_x_in[i]) >= WIDTH || 32'(km_centroids_y_in[i]) >= HEIGHT) begin
                            seed_x_d[i] = DEFAULT_X[i];
                            seed_y_d[i] = DEFAULT_Y[i];
                        end else begin
                            seed_x_d[i] = km_centroids_x_in[i];
                            seed_y_d[i] = km_centroids_y_in[i];
                        end
                    end
                    state_d = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    seed_x_d  = DEFAULT_X;
                    seed_y_d  = DEFAULT_Y;
                    state_d   = S_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            seed_x_q    <= DEFAULT_X;
            seed_y_q    <= DEFAULT_Y;
            pub_x_q     <= '0;
            pub_y_q     <= '0;
            num_balls_q <= 3'd1;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            new_frame_q <= 1'b0;
            pending_q   <= 1'b0;
            drop_q      <= 8'd0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            seed_x_q    <= seed_x_d;
            seed_y_q    <= seed_y_d;
            pub_x_q     <= pub_x_d;
            pub_y_q     <= pub_y_d;
            num_balls_q <= num_balls_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            new_frame_q <= new_frame_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            wd_q        <= wd_d;
        end
    end

    assign km_rst_out         = rst_in || state_q == S_ARM || state_q == S_ABORT;
    assign km_pixel_valid_out = pixel_valid_in && state_q == S_CAPTURE;
    assign km_centroids_x_out = seed_x_q;
    assign km_centroids_y_out = seed_y_q;
    assign km_num_balls_out   = num_balls_q;
    assign km_new_frame_out   = new_frame_q;
    assign centroids_x_out    = pub_x_q;
    assign centroids_y_out    = pub_y_q;
    assign valid_out          = valid_q;
    assign timeout_out        = timeout_q;
    assign busy_out           = state_q != S_IDLE;
    assign drop_count_out     = drop_q;

endmodule

// File: tb/tb_k_means_sequencer.sv
// Self-checking bench for k_means_sequencer: directed frame sequences, a vector table
// for ball-count latching, and randomized frames checked against a frame-level model.
module tb_k_means_sequencer;

    localparam int T_CYC = 50;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            frame_start_in = 1'b0;
    logic            frame_end_in = 1'b0;
    logic            pixel_valid_in = 1'b0;
    logic [2:0]      num_balls_in = 3'd0;
    logic            reseed_in = 1'b0;
    logic            km_rst_out;
    logic [6:0][8:0] km_centroids_x_out;
    logic [6:0][7:0] km_centroids_y_out;
    logic [2:0]      km_num_balls_out;
    logic            km_pixel_valid_out;
    logic            km_new_frame_out;
    logic            km_valid_in = 1'b0;
    logic [6:0][8:0] km_centroids_x_in = '0;
    logic [6:0][7:0] km_centroids_y_in = '0;
    logic [6:0][8:0] centroids_x_out;
    logic [6:0][7:0] centroids_y_out;
    logic            valid_out;
    logic            busy_out;
    logic            timeout_out;
    logic [7:0]      drop_count_out;

    int checks = 0;
    int failures = 0;

    k_means_sequencer #(.TIMEOUT_CYCLES(T_CYC), .WIDTH(320), .HEIGHT(180)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
        .pixel_valid_in(pixel_valid_in), .num_balls_in(num_balls_in),
        .reseed_in(reseed_in), .km_rst_out(km_rst_out),
        .km_centroids_x_out(km_centroids_x_out), .km_centroids_y_out(km_centroids_y_out),
        .km_num_balls_out(km_num_balls_out), .km_pixel_valid_out(km_pixel_valid_out),
        .km_new_frame_out(km_new_frame_out), .km_valid_in(km_valid_in),
        .km_centroids_x_in(km_centroids_x_in), .km_centroids_y_in(km_centroids_y_in),
        .centroids_x_out(centroids_x_out), .centroids_y_out(centroids_y_out),
        .valid_out(valid_out), .busy_out(busy_out), .timeout_out(timeout_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Frame-level model state
    logic [6:0][8:0] m_sx, m_px, def_x, rx;
    logic [6:0][7:0] m_sy, m_py, def_y, ry;
    int m_nb, m_drop;
    bit m_pending;

    typedef struct {
        logic [2:0] num;
        logic [2:0] exp_nb;
        logic [8:0] exp_x0;
        logic [8:0] exp_x6;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic start_frame(input logic [2:0] n);
        num_balls_in = n;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic end_frame();
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0;
    endtask

    task automatic send_result(input logic [6:0][8:0] x, input logic [6:0][7:0] y);
        km_centroids_x_in = x;
        km_centroids_y_in = y;
        km_valid_in = 1'b1;
        tick();
        km_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        m_sx = def_x; m_sy = def_y; m_px = '0; m_py = '0;
        m_nb = 1; m_drop = 0; m_pending = 0;
    endtask

    task automatic random_frame();
        int num, nb, lat, npix;
        bit do_timeout;
        if ($urandom_range(0, 4) == 0) begin
            reseed_in = 1'b1; tick(); reseed_in = 1'b0;
            m_pending = 1;
        end
        num = $urandom_range(0, 7);
        nb = (num == 0) ? 1 : num;
        if (nb != m_nb || m_pending) begin
            m_sx = def_x; m_sy = def_y; m_pending = 0;
        end
        m_nb = nb;
        start_frame(3'(num));
        check("rnd_arm_rst", 64'(km_rst_out), 64'(1));
        check("rnd_nb", 64'(km_num_balls_out), 64'(nb));
        check("rnd_seed_x", 64'(km_centroids_x_out), 64'(m_sx));
        check("rnd_seed_y", 64'(km_centroids_y_out), 64'(m_sy));
        tick();
        npix = $urandom_range(1, 4);
        for (int k = 0; k < npix; k++) begin
            pixel_valid_in = 1'($urandom_range(0, 1));
            #1 check("rnd_pix_gate", 64'(km_pixel_valid_out), 64'(pixel_valid_in));
            tick();
        end
        pixel_valid_in = 1'b0;
        end_frame();
        check("rnd_new_frame", 64'(km_new_frame_out), 64'(1));
        lat = $urandom_range(0, 20);
        for (int k = 0; k < lat; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                frame_start_in = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if ($urandom_range(0, 7) == 0) begin
                reseed_in = 1'b1;
                m_pending = 1;
            end
            tick();
            frame_start_in = 1'b0;
            reseed_in = 1'b0;
        end
        do_timeout = ($urandom_range(0, 5) == 0);
        if (do_timeout) begin
            for (int k = 0; k < T_CYC + 5 && !timeout_out; k++) tick();
            check("rnd_timeout_seen", 64'(timeout_out), 64'(1));
            m_sx = def_x; m_sy = def_y;
            tick();
            check("rnd_abort_idle", 64'(busy_out), 64'(0));
            check("rnd_pub_hold", 64'(centroids_x_out), 64'(m_px));
        end else begin
            for (int i = 0; i < 7; i++) begin
                rx[i] = $urandom_range(0, 1) ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511));
                ry[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 179)) : 8'($urandom_range(0, 255));
            end
            m_px = rx; m_py = ry;
            for (int i = 0; i < 7; i++) begin
                if (int'(rx[i]) < 320 && int'(ry[i]) < 180) begin
                    m_sx[i] = rx[i]; m_sy[i] = ry[i];
                end else begin
                    m_sx[i] = def_x[i]; m_sy[i] = def_y[i];
                end
            end
            send_result(rx, ry);
            check("rnd_valid", 64'(valid_out), 64'(1));
            check("rnd_pub_x", 64'(centroids_x_out), 64'(m_px));
            check("rnd_pub_y", 64'(centroids_y_out), 64'(m_py));
            tick();
            check("rnd_valid_pulse", 64'(valid_out), 64'(0));
        end
        check("rnd_drops", 64'(drop_count_out), 64'(m_drop));
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 7; i++) begin
            def_x[i] = 9'(48 * i + 24);
            def_y[i] = 8'd90;
        end
        tbl[0] = '{3'd0, 3'd1, 9'd24, 9'd312};
        tbl[1] = '{3'd5, 3'd5, 9'd24, 9'd312};
        tbl[2] = '{3'd5, 3'd5, 9'd5,  9'd65};
        tbl[3] = '{3'd7, 3'd7, 9'd24, 9'd312};
        tbl[4] = '{3'd0, 3'd1, 9'd24, 9'd312};
        tbl[5] = '{3'd1, 3'd1, 9'd5,  9'd65};

        // Reset behaviour
        repeat (2) tick();
        check("rst_km_rst_high", 64'(km_rst_out), 64'(1));
        do_reset();
        check("rst_km_rst_low", 64'(km_rst_out), 64'(0));
        check("rst_busy", 64'(busy_out), 64'(0));
        check("rst_nb", 64'(km_num_balls_out), 64'(1));
        check("rst_seeds_x", 64'(km_centroids_x_out), 64'(def_x));
        check("rst_pub_x", 64'(centroids_x_out), 64'(0));
        check("rst_drop", 64'(drop_count_out), 64'(0));
        pixel_valid_in = 1'b1;
        #1 check("idle_pix_gate", 64'(km_pixel_valid_out), 64'(0));
        pixel_valid_in = 1'b0;

        // Frame 1: arm, capture, solve with an out-of-range cluster
        repeat (5) tick();
        start_frame(3'd3);
        check("arm_km_rst", 64'(km_rst_out), 64'(1));
        check("arm_nb", 64'(km_num_balls_out), 64'(3));
        check("arm_seed_x012", 64'(km_centroids_x_out[2:0]), 64'({9'd120, 9'd72, 9'd24}));
        check("arm_seed_y0", 64'(km_centroids_y_out[0]), 64'(90));
        tick();
        check("cap_km_rst", 64'(km_rst_out), 64'(0));
        check("cap_busy", 64'(busy_out), 64'(1));
        pixel_valid_in = 1'b1;
        #1 check("cap_pix_on", 64'(km_pixel_valid_out), 64'(1));
        pixel_valid_in = 1'b0;
        #1 check("cap_pix_off", 64'(km_pixel_valid_out), 64'(0));
        end_frame();
        check("new_frame_t1", 64'(km_new_frame_out), 64'(1));
        pixel_valid_in = 1'b1;
        #1 check("solve_pix_gate", 64'(km_pixel_valid_out), 64'(0));
        pixel_valid_in = 1'b0;
        tick();
        check("new_frame_t2", 64'(km_new_frame_out), 64'(0));
        for (int i = 0; i < 7; i++) begin
            rx[i] = 9'(20 * i); ry[i] = 8'd50;
        end
        rx[0] = 9'd100; rx[1] = 9'd400;
        send_result(rx, ry);
        check("res_valid", 64'(valid_out), 64'(1));
        check("res_pub_x1", 64'(centroids_x_out[1]), 64'(400));
        check("res_busy", 64'(busy_out), 64'(0));
        tick();
        check("res_valid_pulse", 64'(valid_out), 64'(0));

        // Frame 2: tracked seeds, then two drops in SOLVE
        start_frame(3'd3);
        check("trk_x0", 64'(km_centroids_x_out[0]), 64'(100));
        check("trk_x1", 64'(km_centroids_x_out[1]), 64'(72));
        check("trk_y0", 64'(km_centroids_y_out[0]), 64'(50));
        check("trk_y1", 64'(km_centroids_y_out[1]), 64'(90));
        tick();
        end_frame();
        repeat (2) begin
            frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
        end
        check("drop_two", 64'(drop_count_out), 64'(2));
        rx = {7{9'd150}}; ry = {7{8'd60}};
        send_result(rx, ry);

        // Frame 3: drop count saturation
        start_frame(3'd3);
        tick();
        frame_start_in = 1'b1;
        repeat (300) tick();
        frame_start_in = 1'b0;
        check("drop_sat", 64'(drop_count_out), 64'(255));
        end_frame();
        send_result(rx, ry);

        // Frame 4: watchdog abort
        start_frame(3'd3);
        check("pre_to_seed_x0", 64'(km_centroids_x_out[0]), 64'(150));
        tick();
        end_frame();
        repeat (T_CYC - 1) tick();
        check("to_not_yet", 64'(timeout_out), 64'(0));
        check("to_busy", 64'(busy_out), 64'(1));
        tick();
        check("to_pulse", 64'(timeout_out), 64'(1));
        check("to_km_rst", 64'(km_rst_out), 64'(1));
        tick();
        check("to_pulse_end", 64'(timeout_out), 64'(0));
        check("to_idle", 64'(busy_out), 64'(0));
        check("to_seed_x", 64'(km_centroids_x_out), 64'(def_x));
        check("to_seed_y", 64'(km_centroids_y_out), 64'(def_y));

        // Frame 5: result on the last watchdog cycle wins
        start_frame(3'd3);
        tick();
        end_frame();
        repeat (T_CYC - 1) tick();
        rx = {7{9'd200}}; ry = {7{8'd100}};
        send_result(rx, ry);
        check("late_valid", 64'(valid_out), 64'(1));
        check("late_no_to", 64'(timeout_out), 64'(0));
        check("late_pub_x0", 64'(centroids_x_out[0]), 64'(200));
        tick();
        check("late_no_to2", 64'(timeout_out), 64'(0));
        check("late_idle", 64'(busy_out), 64'(0));

        // Frame 6: reseed during SOLVE
        start_frame(3'd3);
        check("rs_seed_trk", 64'(km_centroids_x_out[0]), 64'(200));
        tick();
        end_frame();
        reseed_in = 1'b1; tick(); reseed_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rx[i] = 9'(30 + i); ry[i] = 8'(40 + i);
        end
        send_result(rx, ry);
        check("rs_pub_x", 64'(centroids_x_out), 64'(rx));
        check("rs_pub_y", 64'(centroids_y_out), 64'(ry));
        tick();
        start_frame(3'd3);
        check("rs_seed_def_x", 64'(km_centroids_x_out), 64'(def_x));
        check("rs_seed_def_y", 64'(km_centroids_y_out), 64'(def_y));

        // Reset in the middle of CAPTURE
        tick();
        rst_in = 1'b1;
        tick();
        check("mid_rst_km_rst", 64'(km_rst_out), 64'(1));
        check("mid_rst_busy", 64'(busy_out), 64'(0));
        check("mid_rst_drop", 64'(drop_count_out), 64'(0));
        check("mid_rst_nb", 64'(km_num_balls_out), 64'(1));
        check("mid_rst_pub", 64'(centroids_x_out), 64'(0));
        check("mid_rst_flags", 64'({valid_out, timeout_out, km_new_frame_out}), 64'(0));
        rst_in = 1'b0;
        tick();

        // Ball-count latching and reseed-on-change table
        for (int v = 0; v < 6; v++) begin
            start_frame(tbl[v].num);
            check($sformatf("tbl%0d_nb", v), 64'(km_num_balls_out), 64'(tbl[v].exp_nb));
            check($sformatf("tbl%0d_x0", v), 64'(km_centroids_x_out[0]), 64'(tbl[v].exp_x0));
            check($sformatf("tbl%0d_x6", v), 64'(km_centroids_x_out[6]), 64'(tbl[v].exp_x6));
            tick();
            end_frame();
            for (int i = 0; i < 7; i++) begin
                rx[i] = 9'(10 * i + 5); ry[i] = 8'd20;
            end
            send_result(rx, ry);
            tick();
        end

        // Randomized frames against the frame-level model
        do_reset();
        for (int f = 0; f < 40; f++) random_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/k_means_sequencer.md
# k_means_sequencer

Frame-level controller for the k-means centroid engine. Seeds the engine's centroids and pulses its reset at each frame start, gates the mask pixel stream into it, and forwards end-of-frame. It then waits for a result, with a watchdog, and publishes tracked centroids, which become the next frame's seeds. It sits between the camera/mask pipeline and the k-means block and owns every control input of that block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum SOLVE duration before abort.
- `WIDTH`, default 320: frame width in pixels.
- `HEIGHT`, default 180: frame height in pixels.

Ports:
- `clk_in`  in  1: system clock.
- `rst_in`  in  1: synchronous, active-high reset.
- `frame_start_in`  in  1: one-cycle pulse at start of frame (vsync).
- `frame_end_in`  in  1: one-cycle pulse after last pixel of frame.
- `pixel_valid_in`  in  1: mask bit of the current pixel.
- `num_balls_in`  in  3: requested ball count.
- `reseed_in`  in  1: pulse; request default seeds at the next frame.
- `km_rst_out`  out  1: reset to the engine (loads seeds).
- `km_centroids_x_out`  out  [6:0] x 9: seed x per centroid.
- `km_centroids_y_out`  out  [6:0] x 8: seed y per centroid.
- `km_num_balls_out`  out  3: latched ball count.
- `km_pixel_valid_out`  out  1: gated mask bit.
- `km_new_frame_out`  out  1: end-of-frame pulse to the engine.
- `km_valid_in`  in  1: engine result-valid pulse.
- `km_centroids_x_in`  in  [6:0] x 9: engine result x.
- `km_centroids_y_in`  in  [6:0] x 8: engine result y.
- `centroids_x_out`  out  [6:0] x 9: published x.
- `centroids_y_out`  out  [6:0] x 8: published y.
- `valid_out`  out  1: one-cycle publish strobe.
- `busy_out`  out  1: high in ARM, CAPTURE, SOLVE and ABORT.
- `timeout_out`  out  1: one-cycle pulse on watchdog abort.
- `drop_count_out`  out  8: saturating count of skipped frames.

## Operation
- Default seed i: x = 48*i + 24, y = 90, giving x = 24, 72, …, 312.
- States: IDLE, ARM, CAPTURE, SOLVE, ABORT.
- **IDLE.** On `frame_start_in`:
  - latch `num_balls_in` into `km_num_balls_out`, with 0 clamped to 1;
  - if the latched count differs from the previous one, or a reseed is pending, load default seeds into all 7 seed registers and clear the pending flag;
  - go to ARM.
- **ARM.** Exactly one cycle; `km_rst_out` = 1, so the engine samples the seeds. Then go to CAPTURE.
- **CAPTURE.**
  - `km_pixel_valid_out` = `pixel_valid_in` (combinational gate); it is 0 in every other state.
  - On `frame_end_in`: register `km_new_frame_out` = 1 for one cycle, clear the watchdog, go to SOLVE.
- **SOLVE.** Watchdog counts every cycle.
  - On `km_valid_in`: register all 7 results to `centroids_x_out`/`centroids_y_out`, pulse `valid_out`, go to IDLE.
  - Seed update on result: result i becomes seed i; if x ≥ `WIDTH` or y ≥ `HEIGHT` (empty cluster or divide error), seed i takes its default instead.
  - Published outputs always carry the raw engine result.
  - When the watchdog reaches `TIMEOUT_CYCLES`-1: go to ABORT.
- **ABORT.** One cycle; `km_rst_out` = 1, pulse `timeout_out`, load default seeds, go to IDLE.
- `km_rst_out` = `rst_in` OR ARM OR ABORT.
- `reseed_in` in any state sets the pending flag; it is consumed at the next IDLE frame start.
- `frame_start_in` in CAPTURE, SOLVE or ABORT: the frame is skipped and `drop_count_out` increments, saturating at 255.
- Simultaneous events:
  - `frame_start_in` with `frame_end_in` in CAPTURE: end is processed, start counts as a drop.
  - `km_valid_in` with watchdog expiry in SOLVE: valid wins, no abort.
  - `km_valid_in` outside SOLVE: ignored.

## Timing
- Reset values:
  - state IDLE; `km_rst_out` = 1 while `rst_in` is high;
  - all seeds default; `km_num_balls_out` = 1;
  - `centroids_x_out`/`centroids_y_out` = 0;
  - `valid_out`, `timeout_out`, `km_new_frame_out` = 0; `drop_count_out` = 0;
  - pending flag cleared; watchdog = 0.
- `frame_start_in` at cycle t: ARM (`km_rst_out`) at t+1, CAPTURE from t+2.
- `frame_end_in` at t: `km_new_frame_out` high at t+1 only; SOLVE from t+1.
- `km_valid_in` at s: outputs and seeds updated and `valid_out` high at s+1; IDLE at s+1.
- The watchdog counts from SOLVE entry. Abort is at SOLVE entry + `TIMEOUT_CYCLES`, with `timeout_out` and `km_rst_out` high at that cycle.
- `rst_in` mid-operation: immediate return to reset values on the next edge. `km_rst_out` is held high through reset, so the engine is also reset.

## Test plan
- Reset, `num_balls_in`=3, frame_start at t=10 → `km_rst_out` at t=11, seeds x = 24, 72, 120, y = 90, `km_num_balls_out`=3; 0 → 1 clamp checked separately.
- CAPTURE with `pixel_valid_in` toggling, frame_end at t → `km_new_frame_out` at t+1 only; `km_pixel_valid_out` stays 0 in IDLE and SOLVE.
- Model returns x0=100, y0=50, x1=400 → `valid_out` pulse, `centroids_x_out[1]`=400 published; next ARM seeds x0=100, x1=72.
- Two frame_starts during SOLVE → `drop_count_out`=2; 300 drops → 255.
- `TIMEOUT_CYCLES`=50, no `km_valid_in` → `timeout_out` and `km_rst_out` at SOLVE+50, seeds default, IDLE; `km_valid_in` at exactly cycle 49 → publish, no timeout.
- `reseed_in` during SOLVE, then result → published result intact; next frame seeds default. `rst_in` mid-CAPTURE → all outputs at reset values.
